// File: rtl/snake_game_sequencer_pkg.sv
// Shared definitions for the snake game sequencer.
//   - game_state_t : game-status encoding driven onto game_status
//   - BORDER_*     : legal apple area, one cell inside the playfield border
//   - WIN_SCORE    : score that ends the game with a win
//   - TICK_W       : width of the step-period arithmetic
//   - lfsr_next    : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package snake_game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int BORDER_X_MIN = 1;
  localparam int BORDER_X_MAX = 78;
  localparam int BORDER_Y_MIN = 1;
  localparam int BORDER_Y_MAX = 58;

  localparam logic [2:0] WIN_SCORE = 3'd7;

  localparam int TICK_W = 27;

  // Taps 16,14,13,11 map to bits 15,13,12,10; shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/snake_game_sequencer_apple_lfsr.sv
// apple_lfsr: free-running LFSR plus range folding for apple candidates.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   advance       : latch a new candidate this cycle (apple_req)
//   apple_x_pos   : X_MIN + (lfsr[6:0]  mod X range), held while advance=0
//   apple_y_pos   : Y_MIN + (lfsr[13:8] mod Y range), held while advance=0
module apple_lfsr
  import snake_game_sequencer_pkg::*;
#(
  parameter int          X_MIN     = BORDER_X_MIN,
  parameter int          X_MAX     = BORDER_X_MAX,
  parameter int          Y_MIN     = BORDER_Y_MIN,
  parameter int          Y_MAX     = BORDER_Y_MAX,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [6:0] apple_x_pos,
  output logic [5:0] apple_y_pos
);

  localparam logic [6:0] X_RANGE = 7'(X_MAX - X_MIN + 1);
  localparam logic [5:0] Y_RANGE = 6'(Y_MAX - Y_MIN + 1);

  logic [15:0] lfsr;
  logic [6:0]  x_raw;
  logic [5:0]  y_raw;
  logic [6:0]  x_fold;
  logic [5:0]  y_fold;

  assign x_raw = lfsr[6:0];
  assign y_raw = lfsr[13:8];

  // The raw fields are less than twice the range, so one conditional
  // subtract is a complete modulo.
  assign x_fold = (x_raw >= X_RANGE) ? x_raw - X_RANGE : x_raw;
  assign y_fold = (y_raw >= Y_RANGE) ? y_raw - Y_RANGE : y_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      apple_x_pos <= 7'(X_MIN + 20);
      apple_y_pos <= 6'(Y_MIN + 10);
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (advance) begin
        apple_x_pos <= x_fold + 7'(X_MIN);
        apple_y_pos <= y_fold + 6'(Y_MIN);
      end
    end
  end

endmodule

// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game scheduler for the snake datapath.
// Owns the IDLE/PLAY/PAUSE/OVER state machine, the step tick, the restart
// strobe and the apple-candidate generator.
// Optional feature: define SPEED_RAMP_EN to shorten the step period with
// score (floor TICK_MIN); otherwise the period is the constant TICK_DIV.
// Ports:
//   clk, rst              : 100 MHz clock, asynchronous active-high reset
//   start_bt, pause_bt    : raw asynchronous buttons (synchronised here)
//   is_crash, is_suicide  : head on border / own body, level
//   score[2:0]            : current score
//   apple_req             : controller wants a new apple candidate
//   game_status[1:0]      : 0=IDLE 1=PLAY 2=PAUSE 3=OVER (state register)
//   move_tick             : one-cycle step enable, only in PLAY
//   snake_rst_n           : active-low datapath restart
//   apple_x_pos, apple_y_pos : apple candidate
//   win                   : set in OVER when the game ended by score
// Handshake: apple_req is a level request; every cycle it is high a new
// candidate appears on the apple outputs the next cycle, and the outputs
// hold while it is low. There is no separate acknowledge.
module snake_game_sequencer
  import snake_game_sequencer_pkg::*;
#(
  parameter int          TICK_DIV    = 100_000_000,
  parameter int          TICK_MIN    = 25_000_000,
  parameter int          TICK_STEP   = 10_000_000,
  parameter int          X_MIN       = BORDER_X_MIN,
  parameter int          X_MAX       = BORDER_X_MAX,
  parameter int          Y_MIN       = BORDER_Y_MIN,
  parameter int          Y_MAX       = BORDER_Y_MAX,
  parameter int          RESTART_CYC = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_bt,
  input  logic       pause_bt,
  input  logic       is_crash,
  input  logic       is_suicide,
  input  logic [2:0] score,
  input  logic       apple_req,
  output logic [1:0] game_status,
  output logic       move_tick,
  output logic       snake_rst_n,
  output logic [6:0] apple_x_pos,
  output logic [5:0] apple_y_pos,
  output logic       win
);

  localparam int RC_W = $clog2(RESTART_CYC + 1);

  game_state_t       state;
  logic              start_s1, start_s2, start_d;
  logic              pause_s1, pause_s2, pause_d;
  logic              start_p, pause_p;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] period_cur;
  logic [RC_W-1:0]   rst_cnt;
  logic              armed;  // first tick of this game has been issued

  assign start_p     = start_s2 & ~start_d;
  assign pause_p     = pause_s2 & ~pause_d;
  assign snake_rst_n = (rst_cnt == '0);
  assign game_status = state;

`ifdef SPEED_RAMP_EN
  logic [TICK_W-1:0] step_total;
  logic [TICK_W-1:0] period_next;
  logic [TICK_W-1:0] period_r;

  assign step_total  = TICK_W'(score) * TICK_W'(TICK_STEP);
  assign period_next = (step_total >= TICK_W'(TICK_DIV - TICK_MIN)) ?
                       TICK_W'(TICK_MIN) : TICK_W'(TICK_DIV) - step_total;
  assign period_cur  = period_r;
`else
  assign period_cur  = TICK_W'(TICK_DIV);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      move_tick <= 1'b0;
      win       <= 1'b0;
      tick_cnt  <= '0;
      rst_cnt   <= RC_W'(RESTART_CYC);
      armed     <= 1'b0;
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_d   <= 1'b0;
      pause_s1  <= 1'b0;
      pause_s2  <= 1'b0;
      pause_d   <= 1'b0;
`ifdef SPEED_RAMP_EN
      period_r  <= TICK_W'(TICK_DIV);
`endif
    end else begin
      start_s1  <= start_bt;
      start_s2  <= start_s1;
      start_d   <= start_s2;
      pause_s1  <= pause_bt;
      pause_s2  <= pause_s1;
      pause_d   <= pause_s2;
      move_tick <= 1'b0;

      if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          // Starting while the datapath is still in restart is ignored.
          if (start_p && snake_rst_n) begin
            state    <= ST_PLAY;
            tick_cnt <= '0;
            armed    <= 1'b0;
`ifdef SPEED_RAMP_EN
            period_r <= period_next;
`endif
          end
        end
        ST_PLAY: begin
          if (move_tick) armed <= 1'b1;
          // Crash inputs are stale until the first step of the game.
          if ((is_crash || is_suicide) && armed) begin
            state <= ST_OVER;
            win   <= 1'b0;
          end else if (score == WIN_SCORE) begin
            state <= ST_OVER;
            win   <= 1'b1;
          end else if (pause_p) begin
            state <= ST_PAUSE;
          end else if (tick_cnt == period_cur - 1'b1) begin
            move_tick <= 1'b1;
            tick_cnt  <= '0;
`ifdef SPEED_RAMP_EN
            period_r  <= period_next;
`endif
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_p) begin
            state   <= ST_IDLE;
            rst_cnt <= RC_W'(RESTART_CYC);
            win     <= 1'b0;
          end else if (pause_p) begin
            state <= ST_PLAY;
          end
        end
        ST_OVER: begin
          if (start_p) begin
            state   <= ST_IDLE;
            rst_cnt <= RC_W'(RESTART_CYC);
            win     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  apple_lfsr #(
    .X_MIN     (X_MIN),
    .X_MAX     (X_MAX),
    .Y_MIN     (Y_MIN),
    .Y_MAX     (Y_MAX),
    .LFSR_SEED (LFSR_SEED)
  ) u_apple_lfsr (
    .clk         (clk),
    .rst         (rst),
    .advance     (apple_req),
    .apple_x_pos (apple_x_pos),
    .apple_y_pos (apple_y_pos)
  );

endmodule

// File: tb/tb_snake_game_sequencer.sv
module tb_snake_game_sequencer;

`ifdef SPEED_RAMP_EN
  localparam int TB_DIV = 100;
`else
  localparam int TB_DIV = 10;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_bt = 1'b0;
  logic       pause_bt = 1'b0;
  logic       is_crash = 1'b0;
  logic       is_suicide = 1'b0;
  logic [2:0] score = 3'd0;
  logic       apple_req = 1'b0;
  logic [1:0] game_status;
  logic       move_tick;
  logic       snake_rst_n;
  logic [6:0] apple_x_pos;
  logic [5:0] apple_y_pos;
  logic       win;

  always #5 clk = ~clk;

  snake_game_sequencer #(
    .TICK_DIV  (TB_DIV),
    .TICK_MIN  (75),
    .TICK_STEP (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_bt    (start_bt),
    .pause_bt    (pause_bt),
    .is_crash    (is_crash),
    .is_suicide  (is_suicide),
    .score       (score),
    .apple_req   (apple_req),
    .game_status (game_status),
    .move_tick   (move_tick),
    .snake_rst_n (snake_rst_n),
    .apple_x_pos (apple_x_pos),
    .apple_y_pos (apple_y_pos),
    .win         (win)
  );

  // Reference LFSR: m_used is the register value seen at the latest edge.
  logic [15:0] m_lfsr, m_used;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_used <= 16'hACE1;
    end else begin
      m_used <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges until move_tick is seen, bounded.
  task automatic wait_tick(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move_tick && n < 4 * TB_DIV + 20);
    chk(tag, n, exp);
  endtask

  // Press start for 3 cycles; returns at the cycle the state change shows.
  task automatic press_start();
    start_bt = 1'b1;
    cycles(3);
    start_bt = 1'b0;
  endtask

  int low_cnt;
  int bad_cnt;
  logic [6:0] hold_x;
  logic [5:0] hold_y;
  int ex, ey;

  initial begin
    // ---- reset state ----
    cycles(3);
    chk("rst_status", game_status, 0);
    chk("rst_tick", move_tick, 0);
    chk("rst_snake_rst_n", snake_rst_n, 0);
    chk("rst_win", win, 0);
    chk("rst_apple_x", apple_x_pos, 21);
    chk("rst_apple_y", apple_y_pos, 11);
    rst = 1'b0;

    // ---- 1: restart release and start ----
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!snake_rst_n) low_cnt++;
      @(negedge clk);
    end
    chk("restart_low_cycles", low_cnt, 16);
    start_bt = 1'b1;
    cycles(2);
    chk("start_sync_not_yet", game_status, 0);
    cycles(1);
    chk("start_to_play", game_status, 1);
    start_bt = 1'b0;
    wait_tick("first_tick_period", TB_DIV);
    wait_tick("second_tick_period", TB_DIV);

    // ---- 2: pause at tick counter 6, resume ----
    cycles(4);
    pause_bt = 1'b1;
    cycles(3);
    chk("pause_status", game_status, 2);
    pause_bt = 1'b0;
    bad_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (move_tick || game_status != 2'd2) bad_cnt++;
    end
    chk("paused_quiet", bad_cnt, 0);
    pause_bt = 1'b1;
    cycles(2);
    chk("resume_not_yet", game_status, 2);
    cycles(1);
    chk("resume_status", game_status, 1);
    pause_bt = 1'b0;
    wait_tick("resume_tick", TB_DIV - 6);

    // ---- 3: crash handling ----
    // Already armed: crash raised on a tick cycle is acted on at once.
    is_crash = 1'b1;
    cycles(1);
    chk("crash_status", game_status, 3);
    chk("crash_win", win, 0);
    chk("crash_tick", move_tick, 0);
    bad_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (move_tick) bad_cnt++;
    end
    chk("over_no_tick", bad_cnt, 0);
    is_crash = 1'b0;
    press_start();
    chk("over_to_idle", game_status, 0);
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!snake_rst_n) low_cnt++;
      if (i == 5) start_bt = 1'b1;
      if (i == 7) start_bt = 1'b0;
      @(negedge clk);
    end
    chk("restart2_low_cycles", low_cnt, 16);
    chk("start_during_restart_ignored", game_status, 0);

    // ---- 4a: win by score ----
    press_start();
    chk("play_again", game_status, 1);
    score = 3'd7;
    cycles(1);
    chk("win_status", game_status, 3);
    chk("win_flag", win, 1);
    score = 3'd0;
    press_start();
    chk("win_to_idle", game_status, 0);
    chk("win_cleared", win, 0);
    cycles(20);

    // ---- 4b: crash ignored on first tick, then crash beats score ----
    press_start();
    chk("play_third", game_status, 1);
    wait_tick("third_game_tick", TB_DIV);
    is_crash = 1'b1;
    cycles(1);
    chk("crash_ignored_first_tick", game_status, 1);
    score = 3'd7;
    cycles(1);
    chk("prio_status", game_status, 3);
    chk("prio_win", win, 0);
    score = 3'd0;
    is_crash = 1'b0;

    // ---- 5: apple handshake ----
    chk("apple_x_held", apple_x_pos, 21);
    chk("apple_y_held", apple_y_pos, 11);
    apple_req = 1'b1;
    bad_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ex = 1 + (int'(m_used[6:0]) % 78);
      ey = 1 + (int'(m_used[13:8]) % 58);
      chk("apple_x_candidate", apple_x_pos, ex);
      chk("apple_y_candidate", apple_y_pos, ey);
      if (apple_x_pos < 7'd1 || apple_x_pos > 7'd78 ||
          apple_y_pos < 6'd1 || apple_y_pos > 6'd58) bad_cnt++;
    end
    chk("apple_in_range", bad_cnt, 0);
    apple_req = 1'b0;
    hold_x = apple_x_pos;
    hold_y = apple_y_pos;
    bad_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (apple_x_pos !== hold_x || apple_y_pos !== hold_y) bad_cnt++;
    end
    chk("apple_frozen", bad_cnt, 0);

`ifdef SPEED_RAMP_EN
    // ---- 6: speed ramp ----
    press_start();
    chk("ramp_idle", game_status, 0);
    cycles(20);
    press_start();
    chk("ramp_play", game_status, 1);
    wait_tick("ramp_s0", 100);
    score = 3'd2;
    wait_tick("ramp_s2_old_period", 100);
    wait_tick("ramp_s2", 80);
    score = 3'd5;
    wait_tick("ramp_s5_old_period", 80);
    wait_tick("ramp_s5_sat", 75);
    wait_tick("ramp_s5_sat2", 75);
`endif

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_game_sequencer.md
Name: snake_game_sequencer

Overview:
- Top-level game scheduler for the snake datapath.
- Owns the game state machine (idle/play/pause/over) and generates the snake-step tick, replacing the free-running 1 s clock with a single-clock enable.
- Runs the apple-placement handshake: supplies candidate apple coordinates from an LFSR and advances them while the snake controller keeps requesting a fresh apple.
- Issues the snake datapath's synchronous-restart strobe.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per snake step at base speed.
- TICK_MIN, 25_000_000, floor on step period; used only with SPEED_RAMP_EN.
- TICK_STEP, 10_000_000, period reduction per score point; used only with SPEED_RAMP_EN.
- X_MIN, 1, lowest legal apple x (inside the left border).
- X_MAX, 78, highest legal apple x.
- Y_MIN, 1, lowest legal apple y.
- Y_MAX, 58, highest legal apple y.
- RESTART_CYC, 16, cycles snake_rst_n is held low on restart.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset.
- start_bt  in  1  raw start/restart button, asynchronous.
- pause_bt  in  1  raw pause button, asynchronous.
- is_crash  in  1  head on border, level.
- is_suicide  in  1  head on own body, level.
- score  in  3  current score, 0..7.
- apple_req  in  1  high while the snake controller needs a new apple position.
- game_status  out  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER.
- move_tick  out  1  one-cycle step enable.
- snake_rst_n  out  1  active-low restart to the snake datapath.
- apple_x_pos  out  7  apple x.
- apple_y_pos  out  6  apple y.
- win  out  1  high in OVER when the game ended by score 7.

Behaviour:
- Reset (rst=1, async) sets:
  - game_status=IDLE, move_tick=0, snake_rst_n=0, win=0.
  - LFSR=LFSR_SEED; apple_x_pos=X_MIN+20, apple_y_pos=Y_MIN+10.
  - Tick counter=0; restart counter=RESTART_CYC.
- Buttons:
  - 2-FF synchroniser, then rising-edge detect, giving start_p and pause_p (one cycle each).
  - The datapath does its own debouncing; this block does not debounce.
- snake_rst_n:
  - Held low while the restart counter is nonzero; the counter decrements every cycle.
  - Counter is reloaded to RESTART_CYC on every entry to IDLE.
- State machine:
  - IDLE: on start_p with snake_rst_n=1, go to PLAY. start_p arriving while snake_rst_n=0 is ignored.
  - PLAY:
    - Priority order: is_crash|is_suicide, then score==7, then pause_p.
    - is_crash or is_suicide → OVER with win=0.
    - Else score==7 → OVER with win=1.
    - Else pause_p → PAUSE.
  - PAUSE: pause_p → PLAY. start_p → IDLE (abandon game). If both fire in the same cycle, start_p wins.
  - OVER: start_p → IDLE, win cleared.
- Tick counter:
  - Counts only in PLAY and holds its value in PAUSE.
  - Cleared on entering PLAY from IDLE.
  - On count == period-1: move_tick=1 for one cycle and the counter wraps to 0.
- move_tick is never asserted outside PLAY.
- Crash/suicide are also ignored during the first move_tick's cycle; they are sampled on any PLAY cycle only after the first tick of the game. This filters stale positions right after restart.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-runs every cycle in all states, giving entropy from player timing.
- Apple handshake:
  - On each cycle with apple_req=1, latch a new candidate from the LFSR:
    - x = X_MIN + (lfsr[6:0] mod (X_MAX-X_MIN+1))
    - y = Y_MIN + (lfsr[13:8] mod (Y_MAX-Y_MIN+1))
  - Use the fold-subtract form: if the raw value exceeds the range, subtract the range once. This keeps the output always in range with no divider.
  - While apple_req=0 the outputs are held.
  - A candidate that overlaps the body is rejected by the requester, which keeps apple_req high; this block simply issues the next candidate the following cycle.
- Score wrap: the 3-bit score never wraps in PLAY, because score==7 ends the game first.

Optional Feature:
- SPEED_RAMP_EN defined: period = max(TICK_MIN, TICK_DIV - score*TICK_STEP).
  - Computed with 27-bit unsigned arithmetic and saturated at TICK_MIN.
  - A new period is applied at the next counter wrap, never mid-count.
- SPEED_RAMP_EN undefined: period = TICK_DIV constant; the score input is used only for the win test.

Decomposition:
- Shared package/header holds:
  - Game-status encoding (IDLE/PLAY/PAUSE/OVER).
  - Border constants X_MIN/X_MAX/Y_MIN/Y_MAX, matching the existing border definitions.
  - WIN_SCORE=7.
- One natural sub-module: apple_lfsr, covering the LFSR plus range folding, with ports clk, rst, advance, apple_x_pos, apple_y_pos.
- Button synchronisers stay inline.

Test Plan:
1. Restart release and start:
   - Stimulus: rst pulse, wait 20 cycles, start_bt high 3 cycles; TICK_DIV=10 in sim.
   - Expect: snake_rst_n low for exactly 16 cycles after reset; game_status 0→1 after sync latency of 3 cycles; move_tick every 10 cycles.
2. Pause and resume:
   - Stimulus: in PLAY at tick-counter value 6, pulse pause_bt; wait 50 cycles; pulse pause_bt again.
   - Expect: status=2, no move_tick while paused; first tick after resume arrives 4 cycles after return to PLAY.
3. Crash handling:
   - Stimulus: after the first tick, raise is_crash.
   - Expect: status=3, win=0, move_tick stays 0; then start_bt gives status=0 and snake_rst_n low for 16 cycles.
4. Win and crash priority:
   - Stimulus: set score=7 with is_crash=0; separately score=7 with is_crash=1.
   - Expect: first case status=3, win=1; second case win=0 (crash priority).
5. Apple handshake:
   - Stimulus: hold apple_req high for 200 cycles.
   - Expect: a new candidate every cycle, all with 1≤x≤78 and 1≤y≤58; when apple_req drops, outputs stay frozen for 100 cycles.
6. Speed ramp (SPEED_RAMP_EN, TICK_DIV=100, TICK_STEP=10, TICK_MIN=75):
   - Stimulus: score=0, then 2, then 5.
   - Expect: tick periods 100, 80, 75 (saturated), each change taking effect at the next wrap.
